mem_mp: RTL and testbench
=========================

MEM_MP -- requirements
Module: mem_mp

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per entry.
REQ-002 SHALL have parameter DEPTH, default 32, entry count (any value >= 2; address width AW = $clog2(DEPTH)).
REQ-003 SHALL have parameter READ_PORTS, default 2, number of independent read ports.
REQ-004 SHALL have parameter WRITE_PORTS, default 2, number of independent write ports.
REQ-005 SHALL have parameter BYPASS_EN, default 0, 1 = same-cycle write data forwarded to matching reads.
REQ-006 SHALL have parameter READ_LATENCY, default 0, 0 = combinational read, 1 = registered read.
REQ-007 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-009 SHALL have port clear  input  1  request to re-initialise all entries (RUN only).
REQ-010 SHALL have port ready  output  1  high when the memory accepts reads/writes.
REQ-011 SHALL have port re  input  [READ_PORTS]  per-port read enable.
REQ-012 SHALL have port raddr  input  [READ_PORTS][AW]  per-port read address.
REQ-013 SHALL have port rdata  output  [READ_PORTS][WIDTH]  per-port read data.
REQ-014 SHALL have port rvalid  output  [READ_PORTS]  entry read was written since last init.
REQ-015 SHALL have port we  input  [WRITE_PORTS]  per-port write enable.
REQ-016 SHALL have port waddr  input  [WRITE_PORTS][AW]  per-port write address.
REQ-017 SHALL have port wdata  input  [WRITE_PORTS][WIDTH]  per-port write data.
REQ-018 SHALL have port addr_err  output  1  sticky flag, any enabled access with address >= DEPTH.

Function
REQ-019 SHALL implement a two-state FSM: INIT, RUN.
REQ-020 In INIT, SHALL write zero to entry init_ptr each cycle, init_ptr 0..DEPTH-1, then enter RUN on the cycle after entry DEPTH-1 is written (INIT lasts exactly DEPTH cycles).
REQ-021 ready SHALL equal (state == RUN); re/we SHALL be ignored while ready is low.
REQ-022 A per-entry valid bit SHALL be cleared in a single cycle on entering INIT and set when an entry is written in RUN.
REQ-023 clear high in RUN SHALL enter INIT next cycle with init_ptr = 0; same-cycle writes dropped; clear in INIT SHALL restart init_ptr at 0.
REQ-024 Writes in RUN SHALL update memory at the rising edge; visible to non-bypass reads the following cycle.
REQ-025 Multiple enabled write ports to the same address SHALL resolve with the highest port index winning; all distinct-address writes SHALL commit in the same cycle.
REQ-026 With BYPASS_EN=1, a read whose address matches an enabled same-cycle write SHALL return the winning (highest index) write data and rvalid=1.
REQ-027 With BYPASS_EN=0, same-cycle matching reads SHALL return the pre-write content and pre-write valid bit.
REQ-028 READ_LATENCY=0: rdata/rvalid combinational from current re/raddr; READ_LATENCY=1: rdata/rvalid registered, reflecting re/raddr and (if bypassed) write data sampled the previous cycle.
REQ-029 A port with re=0, ready=0, or raddr >= DEPTH SHALL output rdata=0, rvalid=0 (after READ_LATENCY).
REQ-030 A write with waddr >= DEPTH SHALL be discarded with no effect on any entry.
REQ-031 addr_err SHALL set on the cycle after any enabled RUN-state access with address >= DEPTH and hold until reset.

Reset
REQ-032 reset low at a rising edge SHALL force state=INIT, init_ptr=0, all valid bits=0, addr_err=0, ready=0, registered rdata/rvalid=0.
REQ-033 reset low mid-INIT or mid-RUN SHALL abort current operation and restart INIT from entry 0; memory contents are guaranteed zero only after INIT completes.

Verification
REQ-034 Release reset, DEPTH=32 -> ready low exactly 32 cycles, high on cycle 33; all reads return 0, rvalid=0.
REQ-035 we[0]=we[1]=1, waddr both 5, wdata 0xA/0xB -> next-cycle read addr 5 returns 0xB, rvalid=1.
REQ-036 BYPASS_EN=1, LAT=0: write 0x55 to addr 3 while reading addr 3 -> same-cycle rdata=0x55; BYPASS_EN=0 -> old value 0, rvalid=0.
REQ-037 READ_LATENCY=1: re at cycle N addr 7 holding 0x77 -> rdata=0x77 at N+1; re=0 at N -> rdata=0 at N+1.
REQ-038 clear pulse in RUN with simultaneous write to addr 2 -> write dropped, ready low DEPTH cycles, afterwards addr 2 reads 0, rvalid=0.
REQ-039 DEPTH=24: write addr 30 -> no entry changes, addr_err=1 next cycle and stays 1 until reset low.

Source files
------------

// File: rtl/mem_mp.sv
// Multi-ported memory with per-entry valid bits, a zeroing INIT sweep,
// optional same-cycle write bypass and optional registered read.
module mem_mp #(
  parameter  int unsigned WIDTH        = 32,
  parameter  int unsigned DEPTH        = 32,
  parameter  int unsigned READ_PORTS   = 2,
  parameter  int unsigned WRITE_PORTS  = 2,
  parameter  int unsigned BYPASS_EN    = 0,
  parameter  int unsigned READ_LATENCY = 0,
  localparam int unsigned AW           = $clog2(DEPTH)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 clear,
  output logic                                 ready,
  input  logic [READ_PORTS-1:0]                re,
  input  logic [READ_PORTS-1:0][AW-1:0]        raddr,
  output logic [READ_PORTS-1:0][WIDTH-1:0]     rdata,
  output logic [READ_PORTS-1:0]                rvalid,
  input  logic [WRITE_PORTS-1:0]               we,
  input  logic [WRITE_PORTS-1:0][AW-1:0]       waddr,
  input  logic [WRITE_PORTS-1:0][WIDTH-1:0]    wdata,
  output logic                                 addr_err
);

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {INIT, RUN} state_e;

  state_e                            state_q, state_d;
  logic [AW-1:0]                     init_ptr_q, init_ptr_d;
  logic [WIDTH-1:0]                  mem_q [DEPTH];
  logic [DEPTH-1:0]                  valid_q;
  logic                              addr_err_q, addr_err_d;
  logic                              run;
  logic [WRITE_PORTS-1:0]            wr_ok;
  logic [READ_PORTS-1:0][WIDTH-1:0]  rd_data;
  logic [READ_PORTS-1:0]             rd_vld;

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  assign run      = (state_q == RUN);
  assign ready    = run;
  assign addr_err = addr_err_q;

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    case (state_q)
      INIT: begin
        if (clear) begin
          init_ptr_d = '0;
        end else if (init_ptr_q == LAST) begin
          state_d    = RUN;
          init_ptr_d = '0;
        end else begin
          init_ptr_d = init_ptr_q + AW'(1);
        end
      end
      RUN: begin
        if (clear) begin
          state_d    = INIT;
          init_ptr_d = '0;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_comb begin
    addr_err_d = addr_err_q;
    for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
      wr_ok[w] = run && !clear && we[w] && in_range(waddr[w]);
      if (run && we[w] && !in_range(waddr[w])) addr_err_d = 1'b1;
    end
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      if (run && re[p] && !in_range(raddr[p])) addr_err_d = 1'b1;
    end
  end

  // Bypass scans write ports in ascending order so the highest index wins,
  // matching the commit order of the memory array below.
  always_comb begin
    for (int unsigned p = 0; p < READ_PORTS; p++) begin
      rd_data[p] = '0;
      rd_vld[p]  = 1'b0;
      if (run && re[p] && in_range(raddr[p])) begin
        rd_data[p] = mem_q[raddr[p]];
        rd_vld[p]  = valid_q[raddr[p]];
        if (BYPASS_EN != 0) begin
          for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
            if (wr_ok[w] && (waddr[w] == raddr[p])) begin
              rd_data[p] = wdata[w];
              rd_vld[p]  = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= INIT;
      init_ptr_q <= '0;
      addr_err_q <= 1'b0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
      addr_err_q <= addr_err_d;
      if (run && clear) begin
        valid_q <= '0;
      end else begin
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
          if (wr_ok[w]) valid_q[waddr[w]] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if (!run) begin
        mem_q[init_ptr_q] <= '0;
      end else begin
        for (int unsigned w = 0; w < WRITE_PORTS; w++) begin
          if (wr_ok[w]) mem_q[waddr[w]] <= wdata[w];
        end
      end
    end
  end

  if (READ_LATENCY != 0) begin : g_rd_reg
    logic [READ_PORTS-1:0][WIDTH-1:0] rdata_q;
    logic [READ_PORTS-1:0]            rvalid_q;
    always_ff @(posedge clock) begin
      if (!reset) begin
        rdata_q  <= '0;
        rvalid_q <= '0;
      end else begin
        rdata_q  <= rd_data;
        rvalid_q <= rd_vld;
      end
    end
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end else begin : g_rd_comb
    assign rdata  = rd_data;
    assign rvalid = rd_vld;
  end

endmodule

// File: tb/tb_mem_mp.sv
// Directed bench for mem_mp: four configurations share one stimulus stream
// (plain, bypass, registered read, DEPTH=24).
module tb_mem_mp;

  logic             clock = 1'b0;
  logic             reset, clear;
  logic [1:0]       re, we;
  logic [1:0][4:0]  raddr, waddr;
  logic [1:0][31:0] wdata;

  logic             ready0, ready1, ready2, ready3;
  logic [1:0][31:0] rdata0, rdata1, rdata2, rdata3;
  logic [1:0]       rvalid0, rvalid1, rvalid2, rvalid3;
  logic             aerr0, aerr1, aerr2, aerr3;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  mem_mp #(.WIDTH(32), .DEPTH(32), .BYPASS_EN(0), .READ_LATENCY(0)) u0 (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready0),
    .re(re), .raddr(raddr), .rdata(rdata0), .rvalid(rvalid0),
    .we(we), .waddr(waddr), .wdata(wdata), .addr_err(aerr0));

  mem_mp #(.WIDTH(32), .DEPTH(32), .BYPASS_EN(1), .READ_LATENCY(0)) u1 (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready1),
    .re(re), .raddr(raddr), .rdata(rdata1), .rvalid(rvalid1),
    .we(we), .waddr(waddr), .wdata(wdata), .addr_err(aerr1));

  mem_mp #(.WIDTH(32), .DEPTH(32), .BYPASS_EN(0), .READ_LATENCY(1)) u2 (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready2),
    .re(re), .raddr(raddr), .rdata(rdata2), .rvalid(rvalid2),
    .we(we), .waddr(waddr), .wdata(wdata), .addr_err(aerr2));

  mem_mp #(.WIDTH(32), .DEPTH(24), .BYPASS_EN(0), .READ_LATENCY(0)) u3 (
    .clock(clock), .reset(reset), .clear(clear), .ready(ready3),
    .re(re), .raddr(raddr), .rdata(rdata3), .rvalid(rvalid3),
    .we(we), .waddr(waddr), .wdata(wdata), .addr_err(aerr3));

  task automatic idle();
    re = '0; we = '0; clear = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle();
    re = 2'b11; raddr[0] = 5'd0; raddr[1] = 5'd5;
    repeat (3) @(negedge clock);
    tests++; if ({ready0, ready1, ready2, ready3} !== 4'b0000) begin
      $display("FAIL reset_ready: got %b expected 0000", {ready0, ready1, ready2, ready3}); fails++; end
    tests++; if ({aerr0, aerr1, aerr2, aerr3} !== 4'b0000) begin
      $display("FAIL reset_addr_err: got %b expected 0000", {aerr0, aerr1, aerr2, aerr3}); fails++; end
    tests++; if (rdata2 !== '0 || rvalid2 !== 2'b00) begin
      $display("FAIL reset_reg_rdata: got %0h/%b expected 0/00", rdata2, rvalid2); fails++; end
    tests++; if (rdata0 !== '0 || rvalid0 !== 2'b00) begin
      $display("FAIL reset_comb_rdata: got %0h/%b expected 0/00", rdata0, rvalid0); fails++; end
    reset = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clock);
      tests++; if (ready0 !== (i >= 32)) begin
        $display("FAIL init_ready_d32 cycle %0d: got %b expected %b", i, ready0, (i >= 32)); fails++; end
      tests++; if (ready3 !== (i >= 24)) begin
        $display("FAIL init_ready_d24 cycle %0d: got %b expected %b", i, ready3, (i >= 24)); fails++; end
    end
    #1;
    tests++; if (rdata0 !== '0 || rvalid0 !== 2'b00) begin
      $display("FAIL post_init_read: got %0h/%b expected 0/00", rdata0, rvalid0); fails++; end
    @(negedge clock);
    tests++; if (rdata2 !== '0 || rvalid2 !== 2'b00) begin
      $display("FAIL post_init_read_reg: got %0h/%b expected 0/00", rdata2, rvalid2); fails++; end
    idle();
  endtask

  task automatic test_write_priority();
    @(negedge clock); idle();
    we = 2'b11; waddr[0] = 5'd5; waddr[1] = 5'd5; wdata[0] = 32'hA; wdata[1] = 32'hB;
    @(negedge clock); idle();
    re = 2'b01; raddr[0] = 5'd5; #1;
    tests++; if (rdata0[0] !== 32'hB || rvalid0[0] !== 1'b1) begin
      $display("FAIL wprio_u0: got %0h/%b expected b/1", rdata0[0], rvalid0[0]); fails++; end
    tests++; if (rdata1[0] !== 32'hB || rvalid1[0] !== 1'b1) begin
      $display("FAIL wprio_u1: got %0h/%b expected b/1", rdata1[0], rvalid1[0]); fails++; end
    tests++; if (rdata3[0] !== 32'hB || rvalid3[0] !== 1'b1) begin
      $display("FAIL wprio_u3: got %0h/%b expected b/1", rdata3[0], rvalid3[0]); fails++; end
    tests++; if (rdata2[0] !== 32'h0 || rvalid2[0] !== 1'b0) begin
      $display("FAIL wprio_reg_early: got %0h/%b expected 0/0", rdata2[0], rvalid2[0]); fails++; end
    @(negedge clock); idle(); #1;
    tests++; if (rdata2[0] !== 32'hB || rvalid2[0] !== 1'b1) begin
      $display("FAIL wprio_reg: got %0h/%b expected b/1", rdata2[0], rvalid2[0]); fails++; end
    tests++; if (rdata0[0] !== 32'h0 || rvalid0[0] !== 1'b0) begin
      $display("FAIL re_off: got %0h/%b expected 0/0", rdata0[0], rvalid0[0]); fails++; end
    @(negedge clock); idle();
    we = 2'b11; waddr[0] = 5'd8; waddr[1] = 5'd9; wdata[0] = 32'h18; wdata[1] = 32'h19;
    @(negedge clock); idle();
    re = 2'b11; raddr[0] = 5'd8; raddr[1] = 5'd9; #1;
    tests++; if (rdata0[0] !== 32'h18 || rdata0[1] !== 32'h19 || rvalid0 !== 2'b11) begin
      $display("FAIL wdistinct: got %0h,%0h/%b expected 18,19/11", rdata0[0], rdata0[1], rvalid0); fails++; end
  endtask

  task automatic test_bypass();
    @(negedge clock); idle();
    we = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h55; re = 2'b01; raddr[0] = 5'd3; #1;
    tests++; if (rdata1[0] !== 32'h55 || rvalid1[0] !== 1'b1) begin
      $display("FAIL bypass_on: got %0h/%b expected 55/1", rdata1[0], rvalid1[0]); fails++; end
    tests++; if (rdata0[0] !== 32'h0 || rvalid0[0] !== 1'b0) begin
      $display("FAIL bypass_off: got %0h/%b expected 0/0", rdata0[0], rvalid0[0]); fails++; end
    @(negedge clock); idle();
    re = 2'b01; raddr[0] = 5'd3; #1;
    tests++; if (rdata0[0] !== 32'h55 || rvalid0[0] !== 1'b1) begin
      $display("FAIL bypass_after: got %0h/%b expected 55/1", rdata0[0], rvalid0[0]); fails++; end
    tests++; if (rdata2[0] !== 32'h0 || rvalid2[0] !== 1'b0) begin
      $display("FAIL bypass_reg_prewrite: got %0h/%b expected 0/0", rdata2[0], rvalid2[0]); fails++; end
    @(negedge clock); idle();
    we = 2'b11; waddr[0] = 5'd4; waddr[1] = 5'd4; wdata[0] = 32'h66; wdata[1] = 32'h77;
    re = 2'b10; raddr[1] = 5'd4; #1;
    tests++; if (rdata1[1] !== 32'h77 || rvalid1[1] !== 1'b1) begin
      $display("FAIL bypass_prio: got %0h/%b expected 77/1", rdata1[1], rvalid1[1]); fails++; end
    tests++; if (rdata0[1] !== 32'h0 || rvalid0[1] !== 1'b0) begin
      $display("FAIL bypass_prio_off: got %0h/%b expected 0/0", rdata0[1], rvalid0[1]); fails++; end
  endtask

  task automatic test_latency();
    @(negedge clock); idle();
    we = 2'b01; waddr[0] = 5'd7; wdata[0] = 32'h77;
    @(negedge clock); idle();
    re = 2'b01; raddr[0] = 5'd7; #1;
    tests++; if (rdata2[0] !== 32'h0) begin
      $display("FAIL lat_before: got %0h expected 0", rdata2[0]); fails++; end
    @(negedge clock); idle();
    raddr[0] = 5'd7; #1;
    tests++; if (rdata2[0] !== 32'h77 || rvalid2[0] !== 1'b1) begin
      $display("FAIL lat_one: got %0h/%b expected 77/1", rdata2[0], rvalid2[0]); fails++; end
    tests++; if (rdata0[0] !== 32'h0) begin
      $display("FAIL lat_comb_re_off: got %0h expected 0", rdata0[0]); fails++; end
    @(negedge clock); idle(); #1;
    tests++; if (rdata2[0] !== 32'h0 || rvalid2[0] !== 1'b0) begin
      $display("FAIL lat_re_off: got %0h/%b expected 0/0", rdata2[0], rvalid2[0]); fails++; end
  endtask

  task automatic test_clear();
    @(negedge clock); idle();
    we = 2'b01; waddr[0] = 5'd2; wdata[0] = 32'h12;
    @(negedge clock); idle();
    re = 2'b01; raddr[0] = 5'd2; #1;
    tests++; if (rdata0[0] !== 32'h12 || rvalid0[0] !== 1'b1) begin
      $display("FAIL clear_pre: got %0h/%b expected 12/1", rdata0[0], rvalid0[0]); fails++; end
    @(negedge clock); idle();
    clear = 1'b1; we = 2'b01; waddr[0] = 5'd2; wdata[0] = 32'h22;
    @(negedge clock); idle();
    for (int i = 0; i < 33; i++) begin
      if (i > 0) @(negedge clock);
      tests++; if (ready0 !== (i >= 32)) begin
        $display("FAIL clear_ready_d32 cycle %0d: got %b expected %b", i, ready0, (i >= 32)); fails++; end
      tests++; if (ready3 !== (i >= 24)) begin
        $display("FAIL clear_ready_d24 cycle %0d: got %b expected %b", i, ready3, (i >= 24)); fails++; end
    end
    re = 2'b11; raddr[0] = 5'd2; raddr[1] = 5'd5; #1;
    tests++; if (rdata0 !== '0 || rvalid0 !== 2'b00) begin
      $display("FAIL clear_after_u0: got %0h/%b expected 0/00", rdata0, rvalid0); fails++; end
    tests++; if (rdata1 !== '0 || rvalid1 !== 2'b00) begin
      $display("FAIL clear_after_u1: got %0h/%b expected 0/00", rdata1, rvalid1); fails++; end
  endtask

  task automatic test_addr_err();
    @(negedge clock); idle();
    tests++; if (aerr3 !== 1'b0) begin
      $display("FAIL aerr_pre: got %b expected 0", aerr3); fails++; end
    we = 2'b01; waddr[0] = 5'd30; wdata[0] = 32'hDEAD; #1;
    tests++; if (aerr3 !== 1'b0) begin
      $display("FAIL aerr_same_cycle: got %b expected 0", aerr3); fails++; end
    @(negedge clock); idle();
    re = 2'b11; raddr[0] = 5'd6; raddr[1] = 5'd14; #1;
    tests++; if (aerr3 !== 1'b1) begin
      $display("FAIL aerr_set: got %b expected 1", aerr3); fails++; end
    tests++; if (aerr0 !== 1'b0) begin
      $display("FAIL aerr_inrange_d32: got %b expected 0", aerr0); fails++; end
    tests++; if (rdata3 !== '0 || rvalid3 !== 2'b00) begin
      $display("FAIL aerr_no_alias: got %0h/%b expected 0/00", rdata3, rvalid3); fails++; end
    @(negedge clock); idle();
    re = 2'b01; raddr[0] = 5'd30; #1;
    tests++; if (rdata0[0] !== 32'hDEAD || rvalid0[0] !== 1'b1) begin
      $display("FAIL aerr_d32_write: got %0h/%b expected dead/1", rdata0[0], rvalid0[0]); fails++; end
    tests++; if (rdata3[0] !== 32'h0 || rvalid3[0] !== 1'b0) begin
      $display("FAIL aerr_oob_read: got %0h/%b expected 0/0", rdata3[0], rvalid3[0]); fails++; end
    @(negedge clock); idle();
    repeat (3) @(negedge clock);
    tests++; if (aerr3 !== 1'b1 || aerr0 !== 1'b0) begin
      $display("FAIL aerr_sticky: got %b/%b expected 1/0", aerr3, aerr0); fails++; end
    reset = 1'b0;
    @(negedge clock);
    tests++; if (aerr3 !== 1'b0 || ready3 !== 1'b0) begin
      $display("FAIL aerr_reset: got %b/%b expected 0/0", aerr3, ready3); fails++; end
    reset = 1'b1;
  endtask

  initial begin
    test_reset();
    test_write_priority();
    test_bypass();
    test_latency();
    test_clear();
    test_addr_err();
    @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
